// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access,
// with a starvation limit for fetch, a response timeout and per-stage stall outputs.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_d,
  output logic              err
);

  localparam int SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [SW-1:0] starve_cnt;
  logic [WW-1:0] wait_cnt;
  logic          grant_i, grant_d, finish, timeout, serving;

  assign serving  = (state == SERVE_I) || (state == SERVE_D);
  assign stall_if = if_req & ~if_valid;
  assign stall_d  = d_req & ~d_valid;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    grant_i = 1'b0;
    grant_d = 1'b0;
    finish  = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && (!if_req || (starve_cnt < STARVE_MAX))) begin
          grant_d = 1'b1;
          state_n = SERVE_D;
        end else if (if_req) begin
          grant_i = 1'b1;
          state_n = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        // A response in the last allowed cycle still counts as a completion.
        if (mem_ready) begin
          finish  = 1'b1;
          state_n = DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout = 1'b1;
          state_n = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      if_valid   <= 1'b0;
      d_rdata    <= '0;
      d_valid    <= 1'b0;
      err        <= 1'b0;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;

      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        wait_cnt  <= '0;
        // Only consecutive data grants that actually held fetch off count toward starvation.
        if (!if_req)                      starve_cnt <= '0;
        else if (starve_cnt < STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
      end

      if (grant_i) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        mem_wdata  <= '0;
        wait_cnt   <= '0;
        starve_cnt <= '0;
      end

      if (serving && !finish && !timeout) wait_cnt <= wait_cnt + 1'b1;

      if (finish || timeout) begin
        mem_req <= 1'b0;
        err     <= timeout;
        if (state == SERVE_D) begin
          d_valid <= 1'b1;
          d_rdata <= (finish && !mem_we) ? mem_rdata : '0;
        end else begin
          if_valid <= 1'b1;
          if_rdata <= finish ? mem_rdata : '0;
        end
      end
    end
  end

endmodule
